// File: rtl/tb_pkg.sv
// Shared definitions for the transpose-buffer ping-pong scheduler.
//   bank_state_e    : per-bank fill/drain state
//   FETCH_WIDTH_DEF : default words per fetch (also columns per bank)
//   TB_HEIGHT_DEF   : default rows per bank
//   popcount()      : number of set bits; also used by the datapath compaction logic
package tb_pkg;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    localparam int unsigned FETCH_WIDTH_DEF = 4;
    localparam int unsigned TB_HEIGHT_DEF   = 4;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tb_bank_state.sv
// Per-bank state machine: Empty -> Filling -> Full -> Draining -> Empty.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : Empty (or a bank being freed this cycle) begins filling
//   close      : Filling bank is complete
//   drain      : Full bank is picked up by the read side
//   free       : last column of this bank has been consumed
//   state      : current bank state
module tb_bank_state
    import tb_pkg::*;
#(
    parameter bank_state_e RESET_STATE = BankEmpty
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        close,
    input  logic        drain,
    input  logic        free,
    output bank_state_e state
);

    bank_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BankEmpty:   if (start) state_d = BankFilling;
            BankFilling: if (close) state_d = BankFull;
            BankFull: begin
                if (free) begin
                    state_d = start ? BankFilling : BankEmpty;
                end else if (drain) begin
                    state_d = BankDraining;
                end
            end
            // A freed bank can be handed straight to a stalled write side.
            BankDraining: if (free) state_d = start ? BankFilling : BankEmpty;
            default:      state_d = BankEmpty;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/tb_sched.sv
// Ping-pong controller for the double-banked transpose buffer. Steers memory fetches into
// buffer rows of the filling bank and sequences column readout of the other bank.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   mem_valid/mem_mask/mem_ready : fetch handshake and per-word mask
//   flush                     : close the write bank early if it holds at least one row
//   wr_en/wr_bank/wr_row/wr_count : combinational row write command to the datapath
//   out_valid/out_ready       : column handshake to the consumer
//   rd_bank/rd_col/out_last   : column select and last-column flag
//   stall_in_cnt/stall_out_cnt: saturating stall counters, present only when
//                               TB_SCHED_STALL_CNT_EN is defined
module tb_sched
    import tb_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int unsigned TB_HEIGHT   = TB_HEIGHT_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mem_valid,
    input  logic [FETCH_WIDTH-1:0]           mem_mask,
    output logic                             mem_ready,
    input  logic                             flush,
    output logic                             wr_en,
    output logic                             wr_bank,
    output logic [$clog2(TB_HEIGHT)-1:0]     wr_row,
    output logic [$clog2(FETCH_WIDTH+1)-1:0] wr_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             rd_bank,
    output logic [$clog2(FETCH_WIDTH)-1:0]   rd_col,
`ifdef TB_SCHED_STALL_CNT_EN
    output logic [15:0]                      stall_in_cnt,
    output logic [15:0]                      stall_out_cnt,
`endif
    output logic                             out_last
);

    localparam int unsigned RowW = $clog2(TB_HEIGHT);
    localparam int unsigned ColW = $clog2(FETCH_WIDTH);
    localparam int unsigned CntW = $clog2(FETCH_WIDTH + 1);

    logic            wr_bank_q, rd_bank_q;
    logic [RowW-1:0] row_ptr_q;
    logic [ColW-1:0] rd_col_q;

    bank_state_e bank_st [2];
    logic [1:0]  start, close, drain, free;

    logic accept, close_wr, switch_wr, other_avail;
    logic rd_fire, col_last, free_rd;
    bank_state_e rd_state;

    tb_bank_state #(.RESET_STATE(BankFilling)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[0]),
        .close (close[0]),
        .drain (drain[0]),
        .free  (free[0]),
        .state (bank_st[0])
    );

    tb_bank_state #(.RESET_STATE(BankEmpty)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[1]),
        .close (close[1]),
        .drain (drain[1]),
        .free  (free[1]),
        .state (bank_st[1])
    );

    always_comb begin
        // Write side
        mem_ready = (bank_st[wr_bank_q] == BankFilling);
        accept    = mem_valid && mem_ready;
        wr_en     = accept;
        wr_bank   = wr_bank_q;
        wr_row    = row_ptr_q;
        wr_count  = accept ? CntW'(popcount(32'(mem_mask))) : '0;
        // A flush alongside an accept closes after that accept, so the bank is never empty.
        close_wr  = (accept && (row_ptr_q == RowW'(TB_HEIGHT - 1))) ||
                    (mem_ready && flush && (accept || (row_ptr_q != '0)));

        // Read side
        rd_state  = bank_st[rd_bank_q];
        out_valid = (rd_state == BankFull) || (rd_state == BankDraining);
        rd_fire   = out_valid && out_ready;
        col_last  = (rd_col_q == ColW'(FETCH_WIDTH - 1));
        out_last  = out_valid && col_last;
        free_rd   = rd_fire && col_last;
        rd_bank   = rd_bank_q;
        rd_col    = rd_col_q;

        // Hand the other bank to the writer on close, or while stalled waiting for it;
        // a bank being freed this cycle counts as available.
        other_avail = (bank_st[~wr_bank_q] == BankEmpty) || (free_rd && (rd_bank_q != wr_bank_q));
        switch_wr   = (close_wr || !mem_ready) && other_avail;

        start = '0;
        close = '0;
        drain = '0;
        free  = '0;
        close[wr_bank_q]  = close_wr;
        start[~wr_bank_q] = switch_wr;
        drain[rd_bank_q]  = (rd_state == BankFull);
        free[rd_bank_q]   = free_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            row_ptr_q <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
        end else begin
            if (close_wr) begin
                row_ptr_q <= '0;
            end else if (accept) begin
                row_ptr_q <= row_ptr_q + RowW'(1);
            end
            if (switch_wr) begin
                wr_bank_q <= ~wr_bank_q;
            end
            // Banks fill in alternation, so draining always alternates too.
            if (rd_fire) begin
                rd_col_q <= col_last ? '0 : rd_col_q + ColW'(1);
                if (col_last) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end
        end
    end

`ifdef TB_SCHED_STALL_CNT_EN
    logic [15:0] stall_in_q, stall_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            if (mem_valid && !mem_ready && (stall_in_q != '1)) begin
                stall_in_q <= stall_in_q + 16'd1;
            end
            if (out_valid && !out_ready && (stall_out_q != '1)) begin
                stall_out_q <= stall_out_q + 16'd1;
            end
        end
    end

    assign stall_in_cnt  = stall_in_q;
    assign stall_out_cnt = stall_out_q;
`endif

endmodule

// File: tb/tb_tb_sched.sv
// Scoreboard bench for tb_sched: directed stimulus pushes expected row writes and column
// reads into queues; a monitor pops and compares whenever the DUT presents them.
module tb_tb_sched;

    typedef struct packed {
        logic       bank;
        logic [1:0] row;
        logic [2:0] cnt;
    } wr_exp_t;

    typedef struct packed {
        logic       bank;
        logic [1:0] col;
        logic       last;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_valid = 1'b0;
    logic [3:0] mem_mask = 4'h0;
    logic       mem_ready;
    logic       flush = 1'b0;
    logic       wr_en;
    logic       wr_bank;
    logic [1:0] wr_row;
    logic [2:0] wr_count;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       rd_bank;
    logic [1:0] rd_col;
    logic       out_last;
`ifdef TB_SCHED_STALL_CNT_EN
    logic [15:0] stall_in_cnt, stall_out_cnt;
`endif

    int checks = 0;
    int errors = 0;

    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    wr_exp_t mon_wr;
    rd_exp_t mon_rd;

    tb_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_mask  (mem_mask),
        .mem_ready (mem_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_bank   (wr_bank),
        .wr_row    (wr_row),
        .wr_count  (wr_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_bank   (rd_bank),
        .rd_col    (rd_col),
`ifdef TB_SCHED_STALL_CNT_EN
        .stall_in_cnt  (stall_in_cnt),
        .stall_out_cnt (stall_out_cnt),
`endif
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented write and every accepted column.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_bank", 32'(wr_bank), 32'(mon_wr.bank));
                    check("wr_row", 32'(wr_row), 32'(mon_wr.row));
                    check("wr_count", 32'(wr_count), 32'(mon_wr.cnt));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    check("rd_bank", 32'(rd_bank), 32'(mon_rd.bank));
                    check("rd_col", 32'(rd_col), 32'(mon_rd.col));
                    check("out_last", 32'(out_last), 32'(mon_rd.last));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic bank, input int row, input int cnt);
        wr_exp_t e;
        e.bank = bank;
        e.row  = 2'(row);
        e.cnt  = 3'(cnt);
        exp_wr.push_back(e);
    endtask

    task automatic push_rd(input logic bank, input int col);
        rd_exp_t e;
        e.bank = bank;
        e.col  = 2'(col);
        e.last = (col == 3);
        exp_rd.push_back(e);
    endtask

    task automatic push_rd_bank(input logic bank);
        for (int c = 0; c < 4; c++) push_rd(bank, c);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_mask  = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        @(negedge clk);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_wr_row", 32'(wr_row), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd0);
        check("rst_rd_col", 32'(rd_col), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
`ifdef TB_SCHED_STALL_CNT_EN
        check("rst_stall_in", 32'(stall_in_cnt), 32'd0);
        check("rst_stall_out", 32'(stall_out_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int left;
        left = 60;
        while ((exp_wr.size() + exp_rd.size()) != 0 && left > 0) begin
            @(negedge clk);
            #1;
            left--;
        end
        check(name, 32'(exp_wr.size() + exp_rd.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Back-to-back fill of bank 0, then drain with out_ready high.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_mask  = 4'hF;
            push_wr(1'b0, i, 4);
            step();
        end
        mem_valid = 1'b0;
        push_rd_bank(1'b0);
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_first_col", 32'(rd_col), 32'd0);
        check("t1_wr_bank", 32'(wr_bank), 32'd1);
        check("t1_mem_ready", 32'(mem_ready), 32'd1);
        wait_drain("t1_drain");

        // Fill both banks with the consumer stalled, then release it.
        do_reset();
        mem_valid = 1'b1;
        mem_mask  = 4'hF;
        for (int i = 0; i < 8; i++) begin
            push_wr(1'(i / 4), i % 4, 4);
            step();
            if (i == 3) push_rd_bank(1'b0);
            if (i == 7) push_rd_bank(1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_stall_ready", 32'(mem_ready), 32'd0);
            step();
        end
        mem_valid = 1'b0;
        @(negedge clk);
`ifdef TB_SCHED_STALL_CNT_EN
        check("t2_stall_in_cnt", 32'(stall_in_cnt), 32'd3);
        check("t2_stall_out_cnt", 32'(stall_out_cnt), 32'd7);
`endif
        step();
        out_ready = 1'b1;
        wait_drain("t2_drain");
        @(negedge clk);
        check("t2_ready_after", 32'(mem_ready), 32'd1);
        check("t2_wr_bank_after", 32'(wr_bank), 32'd0);
        check("t2_valid_after", 32'(out_valid), 32'd0);

        // Two rows then flush: bank 0 closes early, next fetch lands in bank 1 row 0.
        do_reset();
        out_ready = 1'b1;
        mem_valid = 1'b1;
        mem_mask  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            push_wr(1'b0, i, 4);
            step();
        end
        mem_valid = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        push_rd_bank(1'b0);
        @(negedge clk);
        check("t3_wr_bank", 32'(wr_bank), 32'd1);
        check("t3_mem_ready", 32'(mem_ready), 32'd1);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        step();
        mem_valid = 1'b1;
        mem_mask  = 4'h3;
        push_wr(1'b1, 0, 2);
        step();
        mem_valid = 1'b0;
        wait_drain("t3_drain");

        // Flush on an empty bank is ignored; sparse and zero masks still take a row.
        do_reset();
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t4_ready", 32'(mem_ready), 32'd1);
        check("t4_wr_bank", 32'(wr_bank), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        step();
        mem_valid = 1'b1;
        mem_mask = 4'b1010; push_wr(1'b0, 0, 2); step();
        mem_mask = 4'b0000; push_wr(1'b0, 1, 0); step();
        mem_mask = 4'b0001; push_wr(1'b0, 2, 1); step();
        mem_mask = 4'b1111; push_wr(1'b0, 3, 4); step();
        mem_valid = 1'b0;
        push_rd_bank(1'b0);
        wait_drain("t5_drain");

        // Reset during drain of column 2 discards everything.
        do_reset();
        out_ready = 1'b1;
        mem_valid = 1'b1;
        mem_mask  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            push_wr(1'b0, i, 4);
            step();
        end
        mem_valid = 1'b0;
        push_rd(1'b0, 0);
        push_rd(1'b0, 1);
        step();
        step();
        check("t6_col_before_rst", 32'(rd_col), 32'd2);
        check("t6_valid_before_rst", 32'(out_valid), 32'd1);
        do_reset();
        mem_valid = 1'b1;
        mem_mask  = 4'hF;
        push_wr(1'b0, 0, 4);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        wait_drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tb_sched.md
# tb_sched

Ping-pong controller for the double-banked transpose buffer. It accepts row fetches from the memory tile and steers each one to a buffer row, tracking fill state per bank. It then sequences column readout to the downstream consumer under a valid/ready handshake, so one bank fills while the other drains. It sits between the memory read port and the transpose buffer datapath and owns every write/read index that datapath consumes.

## Interface
- FETCH_WIDTH, 4, words per memory fetch; also the number of columns per bank
- TB_HEIGHT, 4, rows per bank
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- mem_valid  input  1  memory presents a fetch this cycle
- mem_mask  input  FETCH_WIDTH  per-word valid mask of the fetch
- mem_ready  output  1  controller accepts a fetch this cycle
- flush  input  1  close the current write bank early if it holds ≥1 row
- wr_en  output  1  datapath writes compacted fetch into row wr_row of bank wr_bank
- wr_bank  output  1  bank being filled
- wr_row  output  $clog2(TB_HEIGHT)  row within wr_bank
- wr_count  output  $clog2(FETCH_WIDTH+1)  popcount of mem_mask (compacted word count)
- out_valid  output  1  column rd_col of bank rd_bank is presented
- out_ready  input  1  consumer accepts the column
- rd_bank  output  1  bank being drained
- rd_col  output  $clog2(FETCH_WIDTH)  column index driven to the datapath mux
- out_last  output  1  out_valid on the final column of a bank

## Operation
- Per-bank state: EMPTY, FILLING, FULL, DRAINING. Reset puts bank 0 in FILLING and bank 1 in EMPTY.
- Write side:
  - mem_ready = write bank in FILLING.
  - Accept = mem_valid && mem_ready.
  - On accept: wr_en=1 (combinational), wr_row = row pointer; row pointer +1. A fetch with an all-zero mask is still accepted and writes a zero row.
  - Bank closes to FULL when the row pointer reaches TB_HEIGHT-1 on accept, or when flush && row pointer>0. Flush on the same cycle as an accept counts that accept first.
  - On close: the row pointer clears. If the other bank is EMPTY, it becomes FILLING and wr_bank toggles. Otherwise mem_ready stays low until the other bank is freed.
  - flush with row pointer 0 is ignored.
- Read side:
  - When rd_bank is FULL it becomes DRAINING and out_valid rises.
  - Each out_valid && out_ready advances rd_col. After column FETCH_WIDTH-1 (out_last), rd_col wraps to 0 and the bank goes EMPTY.
  - The rows read are always all TB_HEIGHT rows. Rows not written since flush hold stale data; the consumer masks them.
  - Drain then moves to the other bank if FULL, else out_valid drops.
- A bank freed by the drain side becomes FILLING the same cycle if the write side is stalled waiting for it.
- Simultaneous close of bank A and free of bank B in one cycle is legal and loses no cycle.
- out_valid, once high, holds with a stable rd_bank/rd_col until accepted.

## Timing
- All outputs are zero at reset except mem_ready=1, which is also the reset value of the write-side state.
- wr_en, wr_row, wr_bank and wr_count are combinational from registered state and current inputs. The datapath registers the row at the next edge.
- State and pointer updates happen on the posedge.
- out_valid asserts no earlier than the cycle after the closing write. This gives the datapath one cycle to settle the last row.
- Throughput with no stalls:
  - one fetch per cycle and one column per cycle
  - steady state is fill TB_HEIGHT and drain FETCH_WIDTH, overlapped.
- Asserting rst_n low mid-operation discards both banks immediately, including partial fills; nothing is replayed.

## Configuration
- TB_SCHED_STALL_CNT_EN defined: adds outputs stall_in_cnt and stall_out_cnt, each 16 bits and saturating.
  - stall_in_cnt counts cycles with mem_valid && !mem_ready.
  - stall_out_cnt counts cycles with out_valid && !out_ready.
  - Both clear on reset.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package tb_pkg:
  - bank-state enum (EMPTY, FILLING, FULL, DRAINING)
  - defaults for FETCH_WIDTH and TB_HEIGHT
  - a popcount function reused by the datapath's compaction logic
- One sub-module, tb_bank_state: a per-bank four-state FSM with close/start/free inputs, instantiated twice. The top handles pointers and bank arbitration.

## Test plan
- Reset, then 4 back-to-back fetches with mask 4'hF and out_ready=1 → wr_row 0,1,2,3 on bank 0; out_valid on the cycle after the 4th write; rd_col 0..3; out_last on col 3.
- Continuous fetches with out_ready=0 → 8 accepts (both banks FULL), then mem_ready=0 and stall_in_cnt increments each cycle (macro on).
- 2 fetches then flush=1 → bank 0 FULL with row pointer 0; wr_bank=1; bank 0 drains all 4 columns.
- flush with row pointer 0 → no state change; mem_ready stays 1.
- Mask 4'b1010 → wr_count=2; mask 4'h0 → accepted, wr_count=0, row pointer advances.
- Assert rst_n low during drain of col 2 → out_valid=0 and both banks reset; the next fetch is written to bank 0 row 0.
